// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state, status codes and frame constants for the PS/2 device receiver
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      CLK_LO,
      CLK_HI,
      ACK
   } ps2_state_t;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_PARITY  = 2'b01;
   localparam logic [1:0] ERR_FRAME   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 10;

   // PS/2 uses odd parity across data plus parity bit
   function automatic logic parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
      return ^{par, data};
   endfunction

endpackage

// File: rtl/ps2_dev_rx_if.sv
// rtl/ps2_dev_rx_if.sv - PS/2 line and received-byte bundle between host side and device receiver
interface ps2_dev_rx_if;
   logic       ps2c_in;
   logic       ps2d_in;
   logic       ps2c_oe;
   logic       ps2d_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [1:0] rx_err;
   logic       busy;

   modport slave (
      input  ps2c_in,
      input  ps2d_in,
      output ps2c_oe,
      output ps2d_oe,
      output rx_data,
      output rx_valid,
      output rx_err,
      output busy
   );

   modport master (
      output ps2c_in,
      output ps2d_in,
      input  ps2c_oe,
      input  ps2d_oe,
      input  rx_data,
      input  rx_valid,
      input  rx_err,
      input  busy
   );
endinterface

// File: rtl/ps2_half_timer.sv
// rtl/ps2_half_timer.sv - loadable down-counter; o_done is high for one cycle when a loaded count expires
module ps2_half_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_value,
   output logic             o_done
);

   logic [WIDTH-1:0] r_cnt;
   logic             r_armed;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_armed <= 1'b0;
      end else if (i_load) begin
         r_cnt   <= i_value;
         r_armed <= 1'b1;
      end else if (r_cnt != '0) begin
         r_cnt   <= r_cnt - WIDTH'(1);
      end else begin
         r_armed <= 1'b0;
      end
   end

   assign o_done = r_armed && (r_cnt == '0);

endmodule

// File: rtl/ps2_dev_rx.sv
// rtl/ps2_dev_rx.sv - PS/2 device-side receiver answering a host-to-device write
// Optional: define PS2_DEV_TIMEOUT_EN to time out an unanswered request with rx_err=11.
module ps2_dev_rx
   import ps2_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int HALF_US    = 40,
   parameter int INHIBIT_US = 100,
   parameter int TIMEOUT_US = 2000
) (
   input  logic        clk,
   input  logic        reset,
   ps2_dev_rx_if.slave bus
);

   localparam int CYC_US = CLK_HZ / 1000000;
   localparam int HALF   = CYC_US * HALF_US;
   localparam int INH    = CYC_US * INHIBIT_US;
   localparam int TMO    = CYC_US * TIMEOUT_US;
   localparam int MAXC   = (TMO > INH) ? ((TMO > HALF) ? TMO : HALF) : ((INH > HALF) ? INH : HALF);
   localparam int TW     = $clog2(MAXC + 1);

   ps2_state_t      r_state;
   logic            r_c_s1, r_c_s2, r_d_s1, r_d_s2;
   logic [3:0]      r_idx;
   logic [1:0]      r_guard;
   logic            r_lo_seen;
   logic            r_ack_ph;
   logic [7:0]      r_shift;
   logic            r_par;
   logic            r_stop;
   logic            r_ps2c_oe;
   logic            r_ps2d_oe;
   logic [7:0]      r_rx_data;
   logic            r_rx_valid;
   logic [1:0]      r_rx_err;
   logic            r_busy;

   logic            w_c;
   logic            w_d;
   logic            w_done;
   logic            w_abort;
   logic            w_last_bit;
   logic            w_tmr_load;
   logic [TW-1:0]   w_tmr_val;

   assign w_c        = r_c_s2;
   assign w_d        = r_d_s2;
   assign w_last_bit = (r_idx == 4'(FRAME_BITS - 1));
   // The first cycles of CLK_HI still see our own pull-down through the synchronizer
   assign w_abort    = (r_state == CLK_HI) && (r_guard == 2'd0) && !w_c && r_lo_seen;

   ps2_half_timer #(.WIDTH(TW)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_tmr_load),
      .i_value (w_tmr_val),
      .o_done  (w_done)
   );

   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = TW'(HALF - 1);
      unique case (r_state)
         IDLE: begin
            if (w_c) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = TW'(INH - 1);
            end else if (w_done) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = TW'(TMO - 1);
            end
         end
         INHIBIT: begin
            if (!w_c) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = TW'(TMO - 1);
            end else if (!w_d) begin
               w_tmr_load = 1'b1;
            end
         end
         CLK_LO: begin
            if (w_done) w_tmr_load = 1'b1;
         end
         CLK_HI: begin
            if (w_abort) begin
               // Two inhibit samples are already counted toward the next request
               w_tmr_load = 1'b1;
               w_tmr_val  = TW'(INH - 3);
            end else if (w_done) begin
               w_tmr_load = 1'b1;
               if (w_last_bit && !r_stop) w_tmr_val = TW'(INH - 1);
            end
         end
         ACK: begin
            if (w_done) begin
               w_tmr_load = 1'b1;
               if (r_ack_ph) w_tmr_val = TW'(INH - 1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_c_s1     <= 1'b1;
         r_c_s2     <= 1'b1;
         r_d_s1     <= 1'b1;
         r_d_s2     <= 1'b1;
         r_state    <= IDLE;
         r_idx      <= '0;
         r_guard    <= '0;
         r_lo_seen  <= 1'b0;
         r_ack_ph   <= 1'b0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_stop     <= 1'b0;
         r_ps2c_oe  <= 1'b0;
         r_ps2d_oe  <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_rx_err   <= ERR_OK;
         r_busy     <= 1'b0;
      end else begin
         r_c_s1     <= bus.ps2c_in;
         r_c_s2     <= r_c_s1;
         r_d_s1     <= bus.ps2d_in;
         r_d_s2     <= r_d_s1;
         r_rx_valid <= 1'b0;

         unique case (r_state)
            IDLE: begin
               if (!w_c && w_done) r_state <= INHIBIT;
            end
            INHIBIT: begin
               if (w_c) begin
                  if (!w_d) begin
                     r_state   <= CLK_LO;
                     r_busy    <= 1'b1;
                     r_idx     <= '0;
                     r_ps2c_oe <= 1'b1;
                  end
`ifdef PS2_DEV_TIMEOUT_EN
                  else if (w_done) begin
                     r_state    <= IDLE;
                     r_rx_valid <= 1'b1;
                     r_rx_err   <= ERR_TIMEOUT;
                  end
`else
                  else begin
                     r_state <= IDLE;
                  end
`endif
               end
            end
            CLK_LO: begin
               if (w_done) begin
                  r_state   <= CLK_HI;
                  r_ps2c_oe <= 1'b0;
                  r_guard   <= 2'd3;
               end
            end
            CLK_HI: begin
               if (r_guard != 2'd0) r_guard <= r_guard - 2'd1;
               r_lo_seen <= (r_guard == 2'd0) && !w_c;
               if (r_guard == 2'd3) begin
                  if (r_idx < 4'(DATA_BITS)) r_shift[r_idx[2:0]] <= w_d;
                  else if (w_last_bit)       r_stop <= w_d;
                  else                       r_par  <= w_d;
               end
               if (w_abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (w_done) begin
                  if (!w_last_bit) begin
                     r_idx     <= r_idx + 4'd1;
                     r_state   <= CLK_LO;
                     r_ps2c_oe <= 1'b1;
                  end else if (r_stop) begin
                     r_state   <= ACK;
                     r_ack_ph  <= 1'b0;
                     r_ps2c_oe <= 1'b1;
                     r_ps2d_oe <= 1'b1;
                  end else begin
                     r_state    <= IDLE;
                     r_busy     <= 1'b0;
                     r_rx_valid <= 1'b1;
                     r_rx_err   <= ERR_FRAME;
                     r_rx_data  <= r_shift;
                  end
               end
            end
            ACK: begin
               if (w_done) begin
                  if (!r_ack_ph) begin
                     r_ack_ph  <= 1'b1;
                     r_ps2c_oe <= 1'b0;
                  end else begin
                     r_state    <= IDLE;
                     r_busy     <= 1'b0;
                     r_ps2d_oe  <= 1'b0;
                     r_rx_valid <= 1'b1;
                     r_rx_data  <= r_shift;
                     r_rx_err   <= parity_ok(r_shift, r_par) ? ERR_OK : ERR_PARITY;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.ps2c_oe  = r_ps2c_oe;
   assign bus.ps2d_oe  = r_ps2d_oe;
   assign bus.rx_data  = r_rx_data;
   assign bus.rx_valid = r_rx_valid;
   assign bus.rx_err   = r_rx_err;
   assign bus.busy     = r_busy;

endmodule

// File: tb/tb_ps2_dev_rx.sv
// tb/tb_ps2_dev_rx.sv - directed bench for ps2_dev_rx at 1 MHz (1 cycle = 1 us)
module tb_ps2_dev_rx;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic host_c = 1'b1;
   logic host_d = 1'b1;

   always #5 clk = ~clk;

   ps2_dev_rx_if bus();

   ps2_dev_rx #(
      .CLK_HZ     (1000000),
      .HALF_US    (40),
      .INHIBIT_US (100),
      .TIMEOUT_US (2000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.ps2c_in = host_c & ~bus.ps2c_oe;
   assign bus.ps2d_in = host_d & ~bus.ps2d_oe;

   typedef struct {
      logic [7:0] d;
      logic       p;
      logic       s;
      logic [7:0] exp_data;
      logic [1:0] exp_err;
      int         exp_ack;
      int         exp_lat;
   } vec_t;

   vec_t tbl[8];
   int   tests = 0;
   int   fails = 0;

   int         cyc = 0;
   int         vcnt = 0;
   int         dbl = 0;
   int         ackc = 0;
   int         oec = 0;
   int         cap_cyc = 0;
   logic [7:0] cap_data = 8'h00;
   logic [1:0] cap_err = 2'b00;
   logic       prev_v = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.rx_valid) begin
         vcnt++;
         cap_data = bus.rx_data;
         cap_err  = bus.rx_err;
         cap_cyc  = cyc;
         if (prev_v) dbl++;
      end
      prev_v = bus.rx_valid;
      if (bus.ps2d_oe) ackc++;
      if (bus.ps2c_oe) oec++;
   end

   task automatic check(input string name, input longint got, input longint exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_c_rise(output int t);
      logic prev;
      bit   found;
      prev  = bus.ps2c_oe;
      found = 0;
      t     = -1;
      for (int k = 0; k < 400 && !found; k++) begin
         @(posedge clk);
         #1;
         if (bus.ps2c_oe && !prev) begin
            t     = cyc;
            found = 1;
         end
         prev = bus.ps2c_oe;
      end
   endtask

   task automatic request();
      host_c = 1'b0;
      step(118);
      host_d = 1'b0;
      step(2);
      host_c = 1'b1;
   endtask

   task automatic send_bits(input logic [7:0] d, input logic p, input logic s, input int nbits,
                            output int t0, output logic b0);
      logic [9:0] bits;
      int         t;
      bits = {s, p, d};
      t0   = -1;
      b0   = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         wait_c_rise(t);
         if (i == 0) begin
            t0 = t;
            b0 = bus.busy;
         end
         step(5);
         host_d = bits[i];
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int   t0;
      logic b0;
      int   v0, a0;
      v0 = vcnt;
      a0 = ackc;
      request();
      send_bits(v.d, v.p, v.s, 10, t0, b0);
      step(250);
      host_d = 1'b1;
      step(20);
      check({tag, " busy_in_frame"}, b0, 1);
      check({tag, " valid_count"}, vcnt - v0, 1);
      check({tag, " rx_data"}, cap_data, v.exp_data);
      check({tag, " rx_err"}, cap_err, v.exp_err);
      check({tag, " ack_cycles"}, ackc - a0, v.exp_ack);
      check({tag, " latency"}, cap_cyc - t0, v.exp_lat);
      check({tag, " busy_after"}, bus.busy, 0);
      check({tag, " c_oe_after"}, bus.ps2c_oe, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int   t0;
      logic b0;
      int   v0, a0, o1;
      int   r0;

      tbl[0] = '{8'hED, 1'b1, 1'b1, 8'hED, 2'b00, 80, 880};
      tbl[1] = '{8'hF4, 1'b1, 1'b1, 8'hF4, 2'b01, 80, 880};
      tbl[2] = '{8'h55, 1'b1, 1'b0, 8'h55, 2'b10, 0, 800};
      tbl[3] = '{8'h12, 1'b1, 1'b1, 8'h12, 2'b00, 80, 880};
      tbl[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 2'b00, 80, 880};
      tbl[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 2'b00, 80, 880};
      tbl[6] = '{8'h80, 1'b0, 1'b1, 8'h80, 2'b00, 80, 880};
      tbl[7] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 2'b01, 80, 880};

      reset = 1'b0;
      step(3);
      check("reset c_oe", bus.ps2c_oe, 0);
      check("reset d_oe", bus.ps2d_oe, 0);
      check("reset rx_data", bus.rx_data, 0);
      check("reset rx_valid", bus.rx_valid, 0);
      check("reset rx_err", bus.rx_err, 0);
      check("reset busy", bus.busy, 0);
      reset = 1'b1;
      step(10);

      for (int i = 0; i < 8; i++) begin
         run_vec(tbl[i], $sformatf("vec%0d", i));
         step(30);
      end

      // Host inhibit during CLK_HI after bit 3 of 0xAA
      v0 = vcnt;
      a0 = ackc;
      request();
      send_bits(8'hAA, 1'b1, 1'b1, 4, t0, b0);
      step(40);
      host_c = 1'b0;
      step(10);
      check("abort c_oe", bus.ps2c_oe, 0);
      check("abort d_oe", bus.ps2d_oe, 0);
      check("abort busy", bus.busy, 0);
      check("abort no_valid", vcnt - v0, 0);
      check("abort no_ack", ackc - a0, 0);
      host_d = 1'b1;
      step(20);
      run_vec(tbl[3], "after_abort");
      step(30);

      // Reset pulse mid-frame at bit 5, then a too-short clock-low pulse
      v0 = vcnt;
      request();
      send_bits(8'h5A, 1'b1, 1'b1, 6, t0, b0);
      step(10);
      check("pre_reset c_oe", bus.ps2c_oe, 1);
      reset = 1'b0;
      step(1);
      check("midrst c_oe", bus.ps2c_oe, 0);
      check("midrst d_oe", bus.ps2d_oe, 0);
      check("midrst rx_data", bus.rx_data, 0);
      check("midrst rx_valid", bus.rx_valid, 0);
      check("midrst rx_err", bus.rx_err, 0);
      check("midrst busy", bus.busy, 0);
      reset = 1'b1;
      host_d = 1'b1;
      step(5);
      o1 = oec;
      host_c = 1'b0;
      step(80);
      host_c = 1'b1;
      step(300);
      check("short_pulse no_clock", oec - o1, 0);
      check("short_pulse busy", bus.busy, 0);
      check("midrst no_valid", vcnt - v0, 0);

      // Request released with data high
      v0 = vcnt;
      host_c = 1'b0;
      step(120);
      host_c = 1'b1;
      r0 = cyc;
      step(2100);
`ifdef PS2_DEV_TIMEOUT_EN
      check("timeout valid_count", vcnt - v0, 1);
      check("timeout rx_err", cap_err, 2'b11);
      check("timeout late_enough", (cap_cyc - r0) >= 1998, 1);
      check("timeout early_enough", (cap_cyc - r0) <= 2006, 1);
`else
      check("no_timeout valid_count", vcnt - v0, 0);
      check("no_timeout rx_err", bus.rx_err, 2'b00);
`endif
      check("no_timeout clock", bus.ps2c_oe, 0);
      check("valid double_pulse", dbl, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ps2_dev_rx.md
Name: ps2_dev_rx

Overview:
- Synthesizable PS/2 device-side receiver: the responder to a host-to-device PS/2 write.
- It detects the host request (clock inhibit followed by the start bit), generates the device clock, samples 8 data bits plus parity and stop, and drives the ack bit.
- It presents the received byte to the device-emulation logic. It is the device end of the host transmitter's link and is used as the bench's keyboard model and as a loopback target.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- HALF_US, 40, device clock half-period in us (12.5 kHz PS/2 clock).
- INHIBIT_US, 100, minimum host clock-low time accepted as a request-to-send.
- TIMEOUT_US, 2000, WAIT_START timeout (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- ps2c_in  in  1  raw PS/2 clock line level.
- ps2d_in  in  1  raw PS/2 data line level.
- ps2c_oe  out  1  1 = pull clock line low (open-drain), 0 = release.
- ps2d_oe  out  1  1 = pull data line low, 0 = release.
- rx_data  out  8  last received byte, LSB first on the wire.
- rx_valid  out  1  one-cycle pulse when a frame completes.
- rx_err  out  2  frame status, qualified by rx_valid: 00 ok, 01 parity error, 10 framing error (stop bit low).
- busy  out  1  high from request detect until return to IDLE.

Behaviour:
- Inputs pass through 2-flop synchronizers. Every "line" condition below refers to synchronized values.
- Reset (reset==0 at a clk edge): all outputs 0, state IDLE, counters cleared. Reset mid-frame drops the frame, releases both lines the next cycle and emits no rx_valid.
- Timing: HALF = CLK_HZ/1000000*HALF_US cycles; INH = CLK_HZ/1000000*INHIBIT_US cycles.
- IDLE: lines released. When ps2c low, count cycles; the count resets whenever ps2c goes high.
  - count reaches INH -> INHIBIT.
- INHIBIT: wait for ps2c high.
  - If ps2d low at that moment, or goes low while ps2c is high -> CLK_LO, busy=1, bit index=0.
  - ps2c high and ps2d high with no request -> IDLE.
- CLK_LO: ps2c_oe=1 for HALF cycles -> CLK_HI.
- CLK_HI: ps2c_oe=0 for HALF cycles. Sample ps2d on the first cycle of CLK_HI (device rising edge).
  - Index 0..7: rx shift register bit[index].
  - Index 8: parity.
  - Index 9: stop.
  - After HALF cycles, increment the index and go to CLK_LO.
- After the stop sample:
  - Stop high -> ACK.
  - Stop low -> rx_valid=1, rx_err=10, rx_data updated, no ack, -> IDLE.
- ACK: ps2d_oe=1 for one full device clock (CLK_LO then CLK_HI, 2*HALF cycles), then release ps2d_oe.
  - rx_data loaded.
  - rx_err = 00 if XOR of {parity, data} == 1 (odd), else 01.
  - rx_valid pulses one cycle.
  - -> IDLE.
  - A parity error is still acked.
- Abort: in CLK_HI, if ps2c is low for 2 consecutive synchronized samples (host inhibit), drop the frame, no rx_valid, -> IDLE with the inhibit count preloaded to 2.
- rx_data holds its value between frames. rx_valid is never high for two consecutive cycles.
- Frame length from the first CLK_LO to rx_valid = 11 device clocks = 22*HALF cycles, +1 cycle for the output register.

Optional Feature:
- PS2_DEV_TIMEOUT_EN defined:
  - INHIBIT with ps2c high and ps2d still high for TIMEOUT_US -> IDLE, with a one-cycle rx_valid and rx_err=11 (timeout).
  - Request detection additionally accepts ps2d falling any time before the timeout.
- Undefined:
  - INHIBIT returns to IDLE immediately when ps2c rises with ps2d high.
  - Code 11 is never produced.

Decomposition:
- Package ps2_pkg holds:
  - state enum (IDLE, INHIBIT, CLK_LO, CLK_HI, ACK);
  - rx_err codes ERR_OK, ERR_PARITY, ERR_FRAME, ERR_TIMEOUT;
  - frame constants DATA_BITS=8 and FRAME_BITS=10.
- One sub-module, ps2_half_timer: a loadable down-counter producing a done pulse. It is shared by HALF, INH and timeout counting.

Test Plan:
- Host model holds ps2c low 120 us, releases with ps2d low, then sends 0xED with parity 1 -> rx_data=0xED, rx_err=00, rx_valid 1 cycle, ps2d_oe high across the 11th device clock, busy low afterwards.
- Host sends 0xF4 with parity 1 (even total) -> rx_data=0xF4, rx_err=01, ack still driven.
- Host sends 0x55 with a correct parity bit and stop bit driven 0 -> rx_err=10, ps2d_oe never asserted, state back to IDLE.
- Host pulls ps2c low during CLK_HI after bit 3 of 0xAA -> no rx_valid, ps2c_oe/ps2d_oe released; the next full 0x12 frame is received correctly.
- Reset driven 0 for one cycle mid-frame at bit 5 -> all outputs 0 the next cycle, no rx_valid; a clock-low pulse of 80 us (< INHIBIT_US) afterwards is ignored.
- With PS2_DEV_TIMEOUT_EN: 120 us inhibit, release with ps2d high for 2.1 ms -> rx_valid with rx_err=11 at 2000 us; without the macro, no rx_valid.
